// File: rtl/mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// mac_dot_sequencer
//
// Streams two operand vectors out of synchronous SRAM into one MAC lane and
// returns the accumulated dot product through a valid/ready handshake.
//
// A run clears the MAC and reads N element pairs. It then pushes one
// zero-product "flush" beat into the MAC, waits out the MAC latency and
// captures mac_acc as the result.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start                  request, accepted when busy is low
//   len, base_a, base_b    element count and start addresses, sampled at accept
//   busy                   high from accept until the result handshake completes
//   rd_en                  SRAM read strobe shared by both operand buffers
//   rd_addr_a, rd_addr_b   SRAM read addresses (wrap modulo 2^ADDR_W)
//   rd_data_a, rd_data_b   SRAM read data, valid the cycle after the read edge
//   mac_a, mac_b           MAC operands
//   mac_en, mac_clr        MAC enable and synchronous clear
//   mac_acc                MAC accumulator
//   result, result_valid   captured dot product and its valid flag
//   result_ready           consumer accepts the result
// ---------------------------------------------------------------------------
module mac_dot_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 11,
    parameter int MAC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [DATA_W-1:0] mac_acc,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READ  = 3'd2,
        FLUSH = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int WAIT_W = 8;
    // The flush beat is the first of the MAC_LAT edges.
    // WAIT is entered one edge later, which leaves MAC_LAT-2 counted edges
    // before the capture edge.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MAC_LAT - 2);

    state_t              state_r, state_s;
    logic [LEN_W-1:0]    len_r, len_s;
    logic [ADDR_W-1:0]   base_a_r, base_a_s;
    logic [ADDR_W-1:0]   base_b_r, base_b_s;
    logic [LEN_W-1:0]    idx_r, idx_s;
    logic                dv_r, dv_s;
    logic [WAIT_W-1:0]   wait_r, wait_s;
    logic                busy_r, busy_s;
    logic                rd_en_r, rd_en_s;
    logic [ADDR_W-1:0]   rd_addr_a_r, rd_addr_a_s;
    logic [ADDR_W-1:0]   rd_addr_b_r, rd_addr_b_s;
    logic [DATA_W-1:0]   mac_a_r, mac_a_s;
    logic [DATA_W-1:0]   mac_b_r, mac_b_s;
    logic                mac_en_r, mac_en_s;
    logic                mac_clr_r, mac_clr_s;
    logic [DATA_W-1:0]   result_r, result_s;
    logic                result_valid_r, result_valid_s;

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        state_s        = state_r;
        len_s          = len_r;
        base_a_s       = base_a_r;
        base_b_s       = base_b_r;
        idx_s          = idx_r;
        dv_s           = rd_en_r;      // read issued last cycle -> SRAM data valid now
        wait_s         = wait_r;
        busy_s         = busy_r;
        rd_en_s        = 1'b0;
        rd_addr_a_s    = rd_addr_a_r;
        rd_addr_b_s    = rd_addr_b_r;
        mac_a_s        = mac_a_r;
        mac_b_s        = mac_b_r;
        mac_en_s       = 1'b0;
        mac_clr_s      = 1'b0;
        result_s       = result_r;
        result_valid_s = result_valid_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    len_s     = len;
                    base_a_s  = base_a;
                    base_b_s  = base_b;
                    idx_s     = '0;
                    busy_s    = 1'b1;
                    mac_clr_s = 1'b1;
                    state_s   = CLEAR;
                end else begin
                    state_s   = IDLE;
                end
            end

            CLEAR: begin
                if (len_r == '0) begin
                    // Empty vector: skip the MAC entirely, capture zero next edge.
                    wait_s  = '0;
                    state_s = WAIT;
                end else begin
                    rd_en_s     = 1'b1;
                    rd_addr_a_s = base_a_r;
                    rd_addr_b_s = base_b_r;
                    idx_s       = LEN_W'(1);
                    state_s     = READ;
                end
            end

            READ: begin
                if (idx_r != len_r) begin
                    rd_en_s     = 1'b1;
                    rd_addr_a_s = base_a_r + ADDR_W'(idx_r);
                    rd_addr_b_s = base_b_r + ADDR_W'(idx_r);
                    idx_s       = idx_r + LEN_W'(1);
                end else begin
                    rd_en_s     = 1'b0;
                end

                if (dv_r) begin
                    mac_a_s  = rd_data_a;
                    mac_b_s  = rd_data_b;
                    mac_en_s = 1'b1;
                end else begin
                    mac_en_s = 1'b0;
                end

                // All reads issued and the read pipe drained: the last element
                // is in the MAC now, so follow it with the zero flush beat.
                if ((idx_r == len_r) && !rd_en_r && !dv_r) begin
                    mac_a_s  = '0;
                    mac_b_s  = '0;
                    mac_en_s = 1'b1;
                    state_s  = FLUSH;
                end else begin
                    state_s  = READ;
                end
            end

            FLUSH: begin
                wait_s  = WAIT_LOAD;
                state_s = WAIT;
            end

            WAIT: begin
                if (wait_r == '0) begin
                    result_s       = (len_r == '0) ? '0 : mac_acc;
                    result_valid_s = 1'b1;
                    state_s        = DONE;
                end else begin
                    wait_s         = wait_r - WAIT_W'(1);
                end
            end

            DONE: begin
                if (result_ready) begin
                    result_valid_s = 1'b0;
                    busy_s         = 1'b0;
                    state_s        = IDLE;
                end else begin
                    state_s        = DONE;
                end
            end

            default: begin
                result_valid_s = 1'b0;
                busy_s         = 1'b0;
                state_s        = IDLE;
            end
        endcase
    end

    // State, run context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            len_r          <= '0;
            base_a_r       <= '0;
            base_b_r       <= '0;
            idx_r          <= '0;
            dv_r           <= 1'b0;
            wait_r         <= '0;
            busy_r         <= 1'b0;
            rd_en_r        <= 1'b0;
            rd_addr_a_r    <= '0;
            rd_addr_b_r    <= '0;
            mac_a_r        <= '0;
            mac_b_r        <= '0;
            mac_en_r       <= 1'b0;
            mac_clr_r      <= 1'b0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            len_r          <= len_s;
            base_a_r       <= base_a_s;
            base_b_r       <= base_b_s;
            idx_r          <= idx_s;
            dv_r           <= dv_s;
            wait_r         <= wait_s;
            busy_r         <= busy_s;
            rd_en_r        <= rd_en_s;
            rd_addr_a_r    <= rd_addr_a_s;
            rd_addr_b_r    <= rd_addr_b_s;
            mac_a_r        <= mac_a_s;
            mac_b_r        <= mac_b_s;
            mac_en_r       <= mac_en_s;
            mac_clr_r      <= mac_clr_s;
            result_r       <= result_s;
            result_valid_r <= result_valid_s;
        end
    end

    assign busy         = busy_r;
    assign rd_en        = rd_en_r;
    assign rd_addr_a    = rd_addr_a_r;
    assign rd_addr_b    = rd_addr_b_r;
    assign mac_a        = mac_a_r;
    assign mac_b        = mac_b_r;
    assign mac_en       = mac_en_r;
    assign mac_clr      = mac_clr_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;

endmodule
